// File: rtl/cache_bus_pkg.sv
// Shared encodings for the cache bus arbiter: FSM states, burst owner and the
// default cache-line length.
package cache_bus_pkg;

   localparam int DEFAULT_BURST_LEN = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

endpackage

// File: rtl/bus_rr_arb.sv
// Two-input round-robin grant (Icache vs Dcache). The priority pointer moves
// only when a burst completes, so the side not served last wins a tie.
module bus_rr_arb
   import cache_bus_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   req_i,
   input  logic   req_d,
   input  logic   done,
   input  owner_t done_owner,
   output logic   gnt_i,
   output logic   gnt_d
);

   logic prio_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prio_d <= 1'b1;
      else if (done)
         prio_d <= (done_owner == OWN_I);
   end

   assign gnt_d = req_d & (prio_d | ~req_i);
   assign gnt_i = req_i & ~gnt_d;

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates Icache and Dcache line bursts onto one memory port, one burst in
// flight, with a sticky flag for memory-side protocol violations.
module cache_bus_arbiter
   import cache_bus_pkg::*;
#(
   parameter int BURST_LEN = DEFAULT_BURST_LEN,
   parameter int AW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic          d_req,
   input  logic          i_we,
   input  logic          d_we,
   input  logic [AW-1:0] i_addr,
   input  logic [AW-1:0] d_addr,
   input  logic [AW-1:0] i_wdata,
   input  logic [AW-1:0] d_wdata,
   output logic          i_addr_ok,
   output logic          d_addr_ok,
   output logic          i_data_ok,
   output logic          d_data_ok,
   output logic          i_burst,
   output logic          d_burst,
   output logic [AW-1:0] rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [AW-1:0] mem_wdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok,
   input  logic          mem_last,
   input  logic [AW-1:0] mem_rdata,
   output logic          burst_err
);

   localparam int            CW        = $clog2(BURST_LEN);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   state_t        state, state_nxt;
   owner_t        owner, owner_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          gnt_i, gnt_d, rr_done;
   logic          addr_ok, data_ok, last_beat, err_nxt;
   logic          own_we;
   logic [AW-1:0] own_addr, own_wdata;

   bus_rr_arb u_rr (
      .clk        (clk),
      .rst        (rst),
      .req_i      (i_req),
      .req_d      (d_req),
      .done       (rr_done),
      .done_owner (owner),
      .gnt_i      (gnt_i),
      .gnt_d      (gnt_d)
   );

   assign own_we    = (owner == OWN_D) ? d_we    : i_we;
   assign own_addr  = (owner == OWN_D) ? d_addr  : i_addr;
   assign own_wdata = (owner == OWN_D) ? d_wdata : i_wdata;
   assign last_beat = (state == ST_DATA) && mem_data_ok && (cnt == LAST_BEAT);

   // Memory must flag exactly the final beat, and never strobe data outside DATA.
   assign err_nxt = burst_err | (mem_last != last_beat) |
                    (mem_data_ok && (state != ST_DATA));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= OWN_NONE;
         cnt       <= '0;
         burst_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         cnt       <= cnt_nxt;
         burst_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      cnt_nxt   = cnt;
      rr_done   = 1'b0;
      addr_ok   = 1'b0;
      data_ok   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rdata     = '0;
      case (state)
         ST_IDLE: begin
            if (gnt_i || gnt_d) begin
               owner_nxt = gnt_d ? OWN_D : OWN_I;
               state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            mem_req  = 1'b1;
            mem_we   = own_we;
            mem_addr = own_addr;
            addr_ok  = mem_addr_ok;
            if (mem_addr_ok) begin
               state_nxt = ST_DATA;
               cnt_nxt   = '0;
            end
         end
         ST_DATA: begin
            mem_we    = own_we;
            mem_wdata = own_wdata;
            rdata     = mem_rdata;
            data_ok   = mem_data_ok;
            if (mem_data_ok) begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == LAST_BEAT) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_IDLE;
                  owner_nxt = OWN_NONE;
                  rr_done   = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            owner_nxt = OWN_NONE;
         end
      endcase
   end

   assign i_addr_ok = addr_ok   && (owner == OWN_I);
   assign d_addr_ok = addr_ok   && (owner == OWN_D);
   assign i_data_ok = data_ok   && (owner == OWN_I);
   assign d_data_ok = data_ok   && (owner == OWN_D);
   assign i_burst   = last_beat && (owner == OWN_I);
   assign d_burst   = last_beat && (owner == OWN_D);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomised self-checking bench for cache_bus_arbiter: a memory-side driver
// records what the DUT did per burst, and each scenario task judges it.
module tb_cache_bus_arbiter;

   localparam int BL = 16;
   localparam int AW = 32;
   localparam logic [AW-1:0] I_WBASE = 32'hA500_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0, d_req = 1'b0, i_we = 1'b0, d_we = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0, i_wdata = '0, d_wdata = '0;
   logic          i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, i_burst, d_burst;
   logic [AW-1:0] rdata, mem_addr, mem_wdata;
   logic          mem_req, mem_we, burst_err;
   logic          mem_addr_ok = 1'b0, mem_data_ok = 1'b0, mem_last = 1'b0;
   logic [AW-1:0] mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   // Per-burst observations filled in by do_burst
   bit            o_timeout;
   int            o_wait, o_i_aok, o_d_aok, o_i_dok, o_d_dok, o_i_bst, o_d_bst;
   int            o_bst_beat, o_rd_bad, o_we_bad;
   logic          o_post_req, o_we;
   logic [AW-1:0] o_addr;
   logic [AW-1:0] o_wd [BL];

   wire [3*AW+8:0] all_out = {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, i_burst,
                              d_burst, mem_req, mem_we, burst_err, rdata, mem_addr,
                              mem_wdata};

   cache_bus_arbiter #(.BURST_LEN(BL), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .d_req(d_req), .i_we(i_we), .d_we(d_we),
      .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
      .i_addr_ok(i_addr_ok), .d_addr_ok(d_addr_ok), .i_data_ok(i_data_ok),
      .d_data_ok(d_data_ok), .i_burst(i_burst), .d_burst(d_burst),
      .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_last(mem_last), .mem_rdata(mem_rdata), .burst_err(burst_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   // Plays the memory side of one burst with random stalls; drives requester
   // write data as a function of beat index and records everything seen.
   task automatic do_burst(input bit own_d, input int last_at, input int stop_at,
                           input bit early_drop, input int raise_at);
      int k = 0;
      int cyc = 0;
      int dly;
      bit v;
      o_timeout = 0; o_wait = 0; o_i_aok = 0; o_d_aok = 0; o_i_dok = 0; o_d_dok = 0;
      o_i_bst = 0; o_d_bst = 0; o_bst_beat = -1; o_rd_bad = 0; o_we_bad = 0;
      o_post_req = 1'b0;
      for (int j = 0; j < BL; j++) o_wd[j] = 'x;
      @(negedge clk);
      while (!mem_req && o_wait < 60) begin
         o_wait++;
         @(negedge clk);
      end
      if (!mem_req) begin
         o_timeout = 1;
         return;
      end
      o_addr = mem_addr;
      o_we   = mem_we;
      dly = $urandom_range(0, 2);
      repeat (dly) @(negedge clk);
      mem_addr_ok = 1'b1;
      #1;
      if (i_addr_ok) o_i_aok++;
      if (d_addr_ok) o_d_aok++;
      @(negedge clk);
      mem_addr_ok = 1'b0;
      forever begin
         if (k == raise_at) begin
            if (own_d) i_req = 1'b1; else d_req = 1'b1;
         end
         if (early_drop && k == 2) begin
            if (own_d) d_req = 1'b0; else i_req = 1'b0;
         end
         i_wdata     = I_WBASE + AW'(k);
         d_wdata     = AW'(k);
         v           = ($urandom_range(0, 3) != 0);
         mem_data_ok = v;
         mem_last    = v && (k == last_at);
         mem_rdata   = $urandom;
         #1;
         if (i_addr_ok) o_i_aok++;
         if (d_addr_ok) o_d_aok++;
         if (i_data_ok) o_i_dok++;
         if (d_data_ok) o_d_dok++;
         if (i_burst) begin o_i_bst++; o_bst_beat = k; end
         if (d_burst) begin o_d_bst++; o_bst_beat = k; end
         if (rdata !== mem_rdata) o_rd_bad++;
         if (mem_we !== o_we) o_we_bad++;
         if (v) begin
            o_wd[k] = mem_wdata;
            k++;
         end
         if (k == BL) break;
         if (stop_at >= 0 && k == stop_at) return;
         cyc++;
         if (cyc > 400) begin
            o_timeout = 1;
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
      mem_data_ok = 1'b0;
      mem_last    = 1'b0;
      if (own_d) d_req = 1'b0; else i_req = 1'b0;
      #1;
      o_post_req = mem_req;
   endtask

   task automatic test_reset();
      bit seen_req = 0;
      @(negedge clk);
      #1;
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (mem_req !== 1'b0) seen_req = 1;
      end
      checks++;
      if (seen_req || all_out !== '0) begin
         failures++;
         $display("FAIL idle_no_req: mem_req seen=%0d outputs=%h want quiet", seen_req, all_out);
      end
   endtask

   task automatic test_i_refill();
      @(negedge clk);
      i_we = 1'b0; i_addr = 32'h0000_1000; i_req = 1'b1;
      do_burst(0, BL-1, -1, 0, -1);
      checks++;
      if (o_timeout || o_wait != 0 || o_addr !== 32'h0000_1000 || o_we !== 1'b0) begin
         failures++;
         $display("FAIL i_refill_addr: timeout=%0d wait=%0d addr=%h we=%b want 0/0/00001000/0",
                  o_timeout, o_wait, o_addr, o_we);
      end
      checks++;
      if (o_i_aok != 1 || o_i_dok != BL || o_i_bst != 1 || o_bst_beat != BL-1) begin
         failures++;
         $display("FAIL i_refill_strobes: aok=%0d dok=%0d bst=%0d beat=%0d want 1/%0d/1/%0d",
                  o_i_aok, o_i_dok, o_i_bst, o_bst_beat, BL, BL-1);
      end
      checks++;
      if (o_d_aok + o_d_dok + o_d_bst != 0 || o_rd_bad != 0 || o_post_req !== 1'b0) begin
         failures++;
         $display("FAIL i_refill_quiet: d_strobes=%0d rdata_bad=%0d post_req=%b want 0/0/0",
                  o_d_aok + o_d_dok + o_d_bst, o_rd_bad, o_post_req);
      end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      i_we = 1'b0; i_addr = 32'h0000_2000; d_we = 1'b0; d_addr = 32'h0000_3000;
      i_req = 1'b1; d_req = 1'b1;
      do_burst(1, BL-1, -1, 0, -1);
      checks++;
      if (o_timeout || o_addr !== 32'h0000_3000 || o_d_dok != BL || o_i_dok != 0 || o_d_bst != 1) begin
         failures++;
         $display("FAIL tie_first_d: addr=%h d_dok=%0d i_dok=%0d d_bst=%0d want 00003000/%0d/0/1",
                  o_addr, o_d_dok, o_i_dok, o_d_bst, BL);
      end
      checks++;
      if (o_post_req !== 1'b0) begin
         failures++;
         $display("FAIL tie_idle_gap: mem_req in gap=%b want 0", o_post_req);
      end
      do_burst(0, BL-1, -1, 0, -1);
      checks++;
      if (o_timeout || o_wait != 0 || o_addr !== 32'h0000_2000 || o_i_dok != BL || o_d_dok != 0) begin
         failures++;
         $display("FAIL tie_second_i: wait=%0d addr=%h i_dok=%0d d_dok=%0d want 0/00002000/%0d/0",
                  o_wait, o_addr, o_i_dok, o_d_dok, BL);
      end
   endtask

   task automatic test_d_writeback();
      int bad = 0;
      @(negedge clk);
      d_we = 1'b1; d_addr = 32'h0000_4400; d_req = 1'b1;
      do_burst(1, BL-1, -1, 0, -1);
      for (int j = 0; j < BL; j++) if (o_wd[j] !== AW'(j)) bad++;
      checks++;
      if (o_timeout || o_we !== 1'b1 || o_we_bad != 0 || bad != 0) begin
         failures++;
         $display("FAIL d_wb_data: we=%b we_bad=%0d wdata_bad=%0d want 1/0/0", o_we, o_we_bad, bad);
      end
      checks++;
      if (o_d_bst != 1 || o_bst_beat != BL-1 || o_d_aok != 1 || o_i_aok + o_i_dok + o_i_bst != 0) begin
         failures++;
         $display("FAIL d_wb_strobes: bst=%0d beat=%0d aok=%0d i_strobes=%0d want 1/%0d/1/0",
                  o_d_bst, o_bst_beat, o_d_aok, o_i_aok + o_i_dok + o_i_bst, BL-1);
      end
   endtask

   task automatic test_midburst_req();
      @(negedge clk);
      i_we = 1'b0; i_addr = 32'h0000_5000; d_we = 1'b0; d_addr = 32'h0000_6000;
      i_req = 1'b1;
      do_burst(0, BL-1, -1, 0, 3);
      checks++;
      if (o_timeout || o_i_dok != BL || o_d_aok + o_d_dok + o_d_bst != 0) begin
         failures++;
         $display("FAIL mid_wait: i_dok=%0d d_strobes=%0d want %0d/0",
                  o_i_dok, o_d_aok + o_d_dok + o_d_bst, BL);
      end
      do_burst(1, BL-1, -1, 0, -1);
      checks++;
      if (o_timeout || o_wait != 0 || o_addr !== 32'h0000_6000 || o_d_dok != BL) begin
         failures++;
         $display("FAIL mid_then_d: wait=%0d addr=%h d_dok=%0d want 0/00006000/%0d",
                  o_wait, o_addr, o_d_dok, BL);
      end
   endtask

   task automatic test_early_drop();
      int bad = 0;
      @(negedge clk);
      i_we = 1'b1; i_addr = 32'h0000_7000; i_req = 1'b1;
      do_burst(0, BL-1, -1, 1, -1);
      for (int j = 0; j < BL; j++) if (o_wd[j] !== I_WBASE + AW'(j)) bad++;
      checks++;
      if (o_timeout || o_i_dok != BL || o_i_bst != 1 || bad != 0 || o_post_req !== 1'b0) begin
         failures++;
         $display("FAIL early_drop: dok=%0d bst=%0d wdata_bad=%0d post_req=%b want %0d/1/0/0",
                  o_i_dok, o_i_bst, bad, o_post_req, BL);
      end
   endtask

   task automatic test_random();
      bit last_d = 0;
      @(negedge clk);
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < 10; r++) begin
         int sel = $urandom_range(1, 3);
         int n = (sel == 3) ? 2 : 1;
         bit first_d = (sel == 3) ? !last_d : (sel == 2);
         logic [AW-1:0] ia = $urandom & ~32'h3F;
         logic [AW-1:0] da = $urandom & ~32'h3F;
         logic iw = 1'($urandom_range(0, 1));
         logic dw = 1'($urandom_range(0, 1));
         @(negedge clk);
         i_addr = ia; d_addr = da; i_we = iw; d_we = dw;
         i_req = sel[0]; d_req = sel[1];
         for (int b = 0; b < n; b++) begin
            bit od = (b == 0) ? first_d : !first_d;
            int own_dok, oth;
            do_burst(od, BL-1, -1, 0, -1);
            own_dok = od ? o_d_dok : o_i_dok;
            oth = od ? (o_i_aok + o_i_dok + o_i_bst) : (o_d_aok + o_d_dok + o_d_bst);
            checks++;
            if (o_timeout || o_wait != 0 || o_addr !== (od ? da : ia) || o_we !== (od ? dw : iw)) begin
               failures++;
               $display("FAIL rand_grant r%0d b%0d: addr=%h we=%b wait=%0d want %h/%b/0",
                        r, b, o_addr, o_we, o_wait, od ? da : ia, od ? dw : iw);
            end
            checks++;
            if (own_dok != BL || oth != 0 || o_bst_beat != BL-1 || o_rd_bad != 0 || burst_err !== 1'b0) begin
               failures++;
               $display("FAIL rand_beats r%0d b%0d: dok=%0d other=%0d beat=%0d rd_bad=%0d err=%b want %0d/0/%0d/0/0",
                        r, b, own_dok, oth, o_bst_beat, o_rd_bad, burst_err, BL, BL-1);
            end
            last_d = od;
         end
      end
   endtask

   task automatic test_burst_err();
      @(negedge clk);
      i_we = 1'b0; i_addr = 32'h0000_8000; i_req = 1'b1;
      do_burst(0, 7, -1, 0, -1);
      checks++;
      if (burst_err !== 1'b1) begin
         failures++;
         $display("FAIL err_set: burst_err=%b want 1", burst_err);
      end
      @(negedge clk);
      d_we = 1'b0; d_addr = 32'h0000_9000; d_req = 1'b1;
      do_burst(1, BL-1, -1, 0, -1);
      checks++;
      if (burst_err !== 1'b1 || o_d_dok != BL) begin
         failures++;
         $display("FAIL err_sticky: burst_err=%b d_dok=%0d want 1/%0d", burst_err, o_d_dok, BL);
      end
   endtask

   task automatic test_reset_midburst();
      @(negedge clk);
      i_we = 1'b0; i_addr = 32'h0000_A000; i_req = 1'b1;
      do_burst(0, BL-1, 5, 0, -1);
      @(negedge clk);
      mem_data_ok = 1'b1; mem_addr_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      rst = 1'b1;
      #1;
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL rst_mid_outputs: got %h want 0", all_out);
      end
      i_req = 1'b0; mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      d_we = 1'b0; d_addr = 32'h0000_B000; d_req = 1'b1;
      do_burst(1, BL-1, -1, 0, -1);
      checks++;
      if (o_timeout || o_addr !== 32'h0000_B000 || o_d_dok != BL || o_d_bst != 1 || burst_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_after: addr=%h dok=%0d bst=%0d err=%b want 0000b000/%0d/1/0",
                  o_addr, o_d_dok, o_d_bst, burst_err, BL);
      end
   endtask

   initial begin
      test_reset();
      test_i_refill();
      test_simultaneous();
      test_d_writeback();
      test_midburst_req();
      test_early_drop();
      test_random();
      test_burst_err();
      test_reset_midburst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, 16, words per cache-line burst (power of two, 2..64).
REQ-002 SHALL have parameter AW, 32, address/data width.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_req, d_req  in  1  line-burst request from Icache / Dcache, held until last beat.
REQ-006 SHALL have ports i_we, d_we  in  1  burst direction (1 = writeback, 0 = refill), stable while req.
REQ-007 SHALL have ports i_addr, d_addr  in  AW  line-aligned burst base address.
REQ-008 SHALL have ports i_wdata, d_wdata  in  AW  current writeback beat.
REQ-009 SHALL have ports i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, i_burst, d_burst  out  1  per-requester address accept, beat strobe, last-beat strobe.
REQ-010 SHALL have port rdata  out  AW  refill beat, shared by both requesters.
REQ-011 SHALL have ports mem_req, mem_we  out  1, mem_addr, mem_wdata  out  AW  memory-side request.
REQ-012 SHALL have ports mem_addr_ok, mem_data_ok, mem_last  in  1, mem_rdata  in  AW  memory-side response.
REQ-013 SHALL have port burst_err  out  1  sticky protocol-error flag.

Function
REQ-014 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, one burst in flight.
REQ-015 In IDLE, any req SHALL latch owner at the clock edge and enter ADDR next cycle; no output asserted in IDLE.
REQ-016 Both req in the same IDLE cycle SHALL grant the requester not served last (round-robin); after reset, D wins first.
REQ-017 In ADDR, mem_req=1 and mem_we/mem_addr SHALL be the owner's we/addr combinationally; mem_addr_ok SHALL pass to the owner's addr_ok in the same cycle, entering DATA with beat counter 0.
REQ-018 In DATA, mem_data_ok SHALL pass to the owner's data_ok in the same cycle; rdata=mem_rdata; mem_wdata=owner's wdata; counter +1 per mem_data_ok.
REQ-019 Owner's burst strobe SHALL assert with data_ok when counter==BURST_LEN-1; FSM then returns to IDLE and updates the round-robin pointer.
REQ-020 Non-owner's addr_ok/data_ok/burst SHALL stay 0 at all times; a request arriving mid-burst SHALL wait, with no loss.
REQ-021 Owner dropping req before the last beat SHALL NOT abort the burst; arbiter completes BURST_LEN beats.
REQ-022 burst_err SHALL set when mem_last disagrees with (mem_data_ok and counter==BURST_LEN-1), or mem_data_ok arrives outside DATA; cleared only by rst.
REQ-023 Counter width SHALL be clog2(BURST_LEN); no wrap inside a burst.
REQ-024 Back-to-back: IDLE exit and new grant SHALL cost exactly one idle cycle between bursts.

Reset
REQ-025 rst SHALL force state IDLE, counter 0, owner none, round-robin pointer to D, burst_err 0, all outputs 0, asynchronously, including mid-burst.
REQ-026 After rst deassertion, first grant SHALL occur no earlier than the first clock edge with a req high.

Structure
REQ-027 Package cache_bus_pkg SHALL hold FSM state encoding, owner encoding (OWN_NONE/OWN_I/OWN_D) and default BURST_LEN.
REQ-028 One sub-module, bus_rr_arb (two-input round-robin grant with pointer register), SHALL be used; the rest is flat.

Verification
REQ-029 i_req only, i_we=0, i_addr=0x0000_1000, 16 mem_data_ok beats -> i_addr_ok once, 16 i_data_ok, i_burst on beat 15, d_* all 0.
REQ-030 i_req and d_req same cycle after reset -> D granted (mem_addr=d_addr); next IDLE, I granted with exactly one idle cycle between.
REQ-031 d_we=1 writeback, d_wdata=beat index -> mem_we=1, mem_wdata 0..15 in order, d_burst on 16th beat.
REQ-032 mem_last on beat 7 of 16 -> burst_err=1 and remains 1 through later clean bursts until rst.
REQ-033 rst asserted on beat 5 of a refill -> all outputs 0 immediately; after release, new d_req completes a full 16-beat burst.
REQ-034 d_req raised on beat 3 of an I burst -> no d_* strobe until I burst completes, then D granted.
